// File: rtl/condlogic.sv
// rtl/condlogic.sv - ARM condition evaluation, flag register and gated write enables.
// Define CONDLOGIC_PERF_EN to build in the executed/squashed instruction counters.
module condlogic (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  Cond,
    input  logic [3:0]  ALUFlags,
    input  logic [1:0]  FlagW,
    input  logic        PCS,
    input  logic        NextPC,
    input  logic        RegW,
    input  logic        MemW,
    input  logic        CondSample,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic [3:0]  Flags,
    output logic [31:0] ExecCount,
    output logic [31:0] SkipCount
);

    logic [3:0] r_flags;
    logic       r_cond_ex_delayed;
    logic       w_cond_ex;
    logic [1:0] w_flag_write;
    logic       w_n, w_z, w_c, w_v;

    assign {w_n, w_z, w_c, w_v} = r_flags;

    always_comb begin
        w_cond_ex = 1'b0;
        case (Cond)
            4'b0000: w_cond_ex = w_z;
            4'b0001: w_cond_ex = ~w_z;
            4'b0010: w_cond_ex = w_c;
            4'b0011: w_cond_ex = ~w_c;
            4'b0100: w_cond_ex = w_n;
            4'b0101: w_cond_ex = ~w_n;
            4'b0110: w_cond_ex = w_v;
            4'b0111: w_cond_ex = ~w_v;
            4'b1000: w_cond_ex = w_c & ~w_z;
            4'b1001: w_cond_ex = ~w_c | w_z;
            4'b1010: w_cond_ex = (w_n == w_v);
            4'b1011: w_cond_ex = (w_n != w_v);
            4'b1100: w_cond_ex = ~w_z & (w_n == w_v);
            4'b1101: w_cond_ex = w_z | (w_n != w_v);
            4'b1110: w_cond_ex = 1'b1;
            default: w_cond_ex = 1'b0;
        endcase
    end

    assign w_flag_write = FlagW & {w_cond_ex, w_cond_ex};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags           <= 4'b0000;
            r_cond_ex_delayed <= 1'b0;
        end else begin
            if (w_flag_write[1]) r_flags[3:2] <= ALUFlags[3:2];
            if (w_flag_write[0]) r_flags[1:0] <= ALUFlags[1:0];
            r_cond_ex_delayed <= w_cond_ex;
        end
    end

    // Enables are gated by the condition evaluated in the previous (decode) cycle.
    assign PCWrite  = (PCS & r_cond_ex_delayed) | NextPC;
    assign RegWrite = RegW & r_cond_ex_delayed;
    assign MemWrite = MemW & r_cond_ex_delayed;
    assign Flags    = r_flags;

`ifdef CONDLOGIC_PERF_EN
    logic [31:0] r_exec_count;
    logic [31:0] r_skip_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_exec_count <= 32'd0;
            r_skip_count <= 32'd0;
        end else if (CondSample) begin
            if (w_cond_ex) r_exec_count <= r_exec_count + 32'd1;
            else           r_skip_count <= r_skip_count + 32'd1;
        end
    end

    assign ExecCount = r_exec_count;
    assign SkipCount = r_skip_count;
`else
    logic w_unused_sample;
    assign w_unused_sample = CondSample;
    assign ExecCount       = 32'd0;
    assign SkipCount       = 32'd0;
`endif

endmodule

// File: tb/tb_condlogic.sv
// tb/tb_condlogic.sv - directed self-checking bench for condlogic.
module tb_condlogic;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  Cond;
    logic [3:0]  ALUFlags;
    logic [1:0]  FlagW;
    logic        PCS, NextPC, RegW, MemW, CondSample;
    logic        PCWrite, RegWrite, MemWrite;
    logic [3:0]  Flags;
    logic [31:0] ExecCount, SkipCount;

    int errors = 0;
    int checks = 0;

    condlogic dut (
        .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
        .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .CondSample(CondSample),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite), .Flags(Flags),
        .ExecCount(ExecCount), .SkipCount(SkipCount)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        Cond = 4'b1111; ALUFlags = 4'b0000; FlagW = 2'b00;
        PCS = 1'b0; NextPC = 1'b0; RegW = 1'b0; MemW = 1'b0; CondSample = 1'b0;
    endtask

    task automatic set_flags(input logic [3:0] f);
        Cond = 4'b1110; FlagW = 2'b11; ALUFlags = f;
        step();
        FlagW = 2'b00;
    endtask

    task automatic test_reset;
        idle_inputs();
        reset = 1'b1;
        RegW = 1'b1; MemW = 1'b1; PCS = 1'b1;
        step();
        checks++; if (Flags !== 4'b0000) begin errors++; $display("FAIL reset_flags actual=%b required=0000", Flags); end
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite actual=%b required=0", RegWrite); end
        checks++; if (MemWrite !== 1'b0) begin errors++; $display("FAIL reset_memwrite actual=%b required=0", MemWrite); end
        checks++; if (PCWrite !== 1'b0) begin errors++; $display("FAIL reset_pcwrite_np0 actual=%b required=0", PCWrite); end
        NextPC = 1'b1; #1;
        checks++; if (PCWrite !== 1'b1) begin errors++; $display("FAIL reset_pcwrite_np1 actual=%b required=1", PCWrite); end
        checks++; if (ExecCount !== 32'd0) begin errors++; $display("FAIL reset_exec actual=%0d required=0", ExecCount); end
        checks++; if (SkipCount !== 32'd0) begin errors++; $display("FAIL reset_skip actual=%0d required=0", SkipCount); end
        idle_inputs();
        reset = 1'b0;
    endtask

    task automatic test_eq_fail;
        Cond = 4'b0000; FlagW = 2'b11; ALUFlags = 4'b0100; RegW = 1'b1;
        step();
        checks++; if (Flags !== 4'b0000) begin errors++; $display("FAIL eq_fail_flags actual=%b required=0000", Flags); end
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL eq_fail_regwrite actual=%b required=0", RegWrite); end
        idle_inputs();
    endtask

    task automatic test_flag_update;
        Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0110; RegW = 1'b1;
        step();
        checks++; if (Flags !== 4'b0110) begin errors++; $display("FAIL al_flags actual=%b required=0110", Flags); end
        Cond = 4'b0000; FlagW = 2'b00; ALUFlags = 4'b0000;
        step();
        checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL eq_pass_regwrite actual=%b required=1", RegWrite); end
        // EQ evaluated on old Z=1 while the same op clears Z
        Cond = 4'b0000; FlagW = 2'b11; ALUFlags = 4'b0000;
        step();
        checks++; if (Flags !== 4'b0000) begin errors++; $display("FAIL old_flags_update actual=%b required=0000", Flags); end
        checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL old_flags_regwrite actual=%b required=1", RegWrite); end
        FlagW = 2'b00;
        ALUFlags = 4'b1111; #1;
        checks++; if (Flags !== 4'b0000) begin errors++; $display("FAIL no_bypass actual=%b required=0000", Flags); end
        idle_inputs();
    endtask

    task automatic test_conds;
        logic [3:0] tf [22] = '{4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b1000, 4'b1000, 4'b1000, 4'b1000,
                                4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0110, 4'b0110, 4'b0110, 4'b0110,
                                4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
        logic [3:0] tc [22] = '{4'b1010, 4'b1100, 4'b1011, 4'b1101, 4'b1011, 4'b1010, 4'b0100, 4'b0101,
                                4'b0010, 4'b0011, 4'b1000, 4'b1001, 4'b1000, 4'b1001, 4'b0000, 4'b0001,
                                4'b0110, 4'b0111, 4'b1111, 4'b1110, 4'b0111, 4'b0101};
        logic       te [22] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                                1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
                                1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 22; i++) begin
            set_flags(tf[i]);
            Cond = tc[i]; RegW = 1'b1;
            step();
            checks++;
            if (RegWrite !== te[i]) begin
                errors++;
                $display("FAIL cond_%b_flags_%b actual=%b required=%b", tc[i], tf[i], RegWrite, te[i]);
            end
            RegW = 1'b0;
        end
        idle_inputs();
    endtask

    task automatic test_partial_flags;
        set_flags(4'b0000);
        Cond = 4'b1110; FlagW = 2'b01; ALUFlags = 4'b1111;
        step();
        checks++; if (Flags !== 4'b0011) begin errors++; $display("FAIL flagw01 actual=%b required=0011", Flags); end
        FlagW = 2'b10; ALUFlags = 4'b1100;
        step();
        checks++; if (Flags !== 4'b1111) begin errors++; $display("FAIL flagw10 actual=%b required=1111", Flags); end
        Cond = 4'b1111; FlagW = 2'b11; ALUFlags = 4'b0000;
        step();
        checks++; if (Flags !== 4'b1111) begin errors++; $display("FAIL nv_no_flags actual=%b required=1111", Flags); end
        idle_inputs();
    endtask

    task automatic test_never;
        Cond = 4'b1111; PCS = 1'b1; MemW = 1'b1; NextPC = 1'b0;
        step();
        checks++; if (PCWrite !== 1'b0) begin errors++; $display("FAIL nv_pcwrite actual=%b required=0", PCWrite); end
        checks++; if (MemWrite !== 1'b0) begin errors++; $display("FAIL nv_memwrite actual=%b required=0", MemWrite); end
        NextPC = 1'b1; #1;
        checks++; if (PCWrite !== 1'b1) begin errors++; $display("FAIL nextpc_after_squash actual=%b required=1", PCWrite); end
        Cond = 4'b1110; NextPC = 1'b0;
        step();
        checks++; if (PCWrite !== 1'b1) begin errors++; $display("FAIL al_pcwrite actual=%b required=1", PCWrite); end
        checks++; if (MemWrite !== 1'b1) begin errors++; $display("FAIL al_memwrite actual=%b required=1", MemWrite); end
        idle_inputs();
    endtask

    task automatic test_reset_mid;
        Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b1010; RegW = 1'b1; MemW = 1'b1;
        reset = 1'b1;
        step();
        checks++; if (Flags !== 4'b0000) begin errors++; $display("FAIL midreset_flags actual=%b required=0000", Flags); end
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL midreset_regwrite actual=%b required=0", RegWrite); end
        checks++; if (MemWrite !== 1'b0) begin errors++; $display("FAIL midreset_memwrite actual=%b required=0", MemWrite); end
        reset = 1'b0;
        idle_inputs();
    endtask

    task automatic test_counters;
        reset = 1'b1; step(); reset = 1'b0;
        Cond = 4'b1110; CondSample = 1'b1;
        step(); step(); step();
        Cond = 4'b1111;
        step(); step(); step(); step(); step();
        CondSample = 1'b0;
        step();
`ifdef CONDLOGIC_PERF_EN
        checks++; if (ExecCount !== 32'd3) begin errors++; $display("FAIL exec_count actual=%0d required=3", ExecCount); end
        checks++; if (SkipCount !== 32'd5) begin errors++; $display("FAIL skip_count actual=%0d required=5", SkipCount); end
        force dut.r_exec_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_exec_count;
        Cond = 4'b1110; CondSample = 1'b1;
        step();
        CondSample = 1'b0;
        checks++; if (ExecCount !== 32'd0) begin errors++; $display("FAIL exec_wrap actual=%h required=00000000", ExecCount); end
        checks++; if (SkipCount !== 32'd5) begin errors++; $display("FAIL skip_after_wrap actual=%0d required=5", SkipCount); end
`else
        checks++; if (ExecCount !== 32'd0) begin errors++; $display("FAIL exec_disabled actual=%0d required=0", ExecCount); end
        checks++; if (SkipCount !== 32'd0) begin errors++; $display("FAIL skip_disabled actual=%0d required=0", SkipCount); end
`endif
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_eq_fail();
        test_flag_update();
        test_conds();
        test_partial_flags();
        test_never();
        test_reset_mid();
        test_counters();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
